// File: rtl/cam_r_unloader.sv
// cam_r_unloader: sweeps the CAM R read addresses (row or column mode), captures
// each sample one cycle after its address and streams it out through a 2-entry
// FIFO on a valid/ready interface.
//
// state | meaning
// IDLE  | waiting for start; busy low
// READ  | issuing addresses 0..N-1, throttled by FIFO space
// DRAIN | all addresses issued; waiting for last read and last pop
// DONE  | one-cycle done pulse
module cam_r_unloader #(
  parameter int DATA_WIDTH     = 4,
  parameter int DATA_DEPTH     = 4,
  parameter int ADDR_WIDTH_CAM = 8,
  parameter int OUT_WIDTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      col_mode,
  input  logic [ADDR_WIDTH_CAM-1:0] len,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Row_R,
  output logic [ADDR_WIDTH_CAM-1:0] addr_output_Col_R,
  input  logic [DATA_WIDTH-1:0]     Q_out_R_row,
  input  logic [DATA_DEPTH-1:0]     Q_out_R_col,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [ADDR_WIDTH_CAM-1:0] out_index,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam logic [ADDR_WIDTH_CAM-1:0] MAX_ROW = ADDR_WIDTH_CAM'(DATA_DEPTH);
  localparam logic [ADDR_WIDTH_CAM-1:0] MAX_COL = ADDR_WIDTH_CAM'(DATA_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                    state_q, state_d;
  logic                      col_mode_q, col_mode_d;
  logic [ADDR_WIDTH_CAM-1:0] n_q, n_d;
  logic [ADDR_WIDTH_CAM-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH_CAM-1:0] addr_row_q, addr_row_d;
  logic [ADDR_WIDTH_CAM-1:0] addr_col_q, addr_col_d;
  logic                      rd_pend_q, rd_pend_d;
  logic                      wr_ptr_q, wr_ptr_d;
  logic                      rd_ptr_q, rd_ptr_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]      fifo_data_q [2];
  logic [OUT_WIDTH-1:0]      fifo_data_d [2];
  logic [ADDR_WIDTH_CAM-1:0] fifo_idx_q  [2];
  logic [ADDR_WIDTH_CAM-1:0] fifo_idx_d  [2];

  logic [OUT_WIDTH-1:0]      sample;
  logic [ADDR_WIDTH_CAM-1:0] cur_addr;
  logic [ADDR_WIDTH_CAM-1:0] max_len;
  logic [ADDR_WIDTH_CAM-1:0] n_start;
  logic                      pop;
  logic                      push;
  logic [2:0]                occ;
  logic                      issue_ok;

  // Stream outputs come straight from the FIFO head; data is masked when empty.
  always_comb begin
    out_valid         = (cnt_q != 2'd0);
    out_data          = out_valid ? fifo_data_q[rd_ptr_q] : '0;
    out_index         = out_valid ? fifo_idx_q[rd_ptr_q]  : '0;
    busy              = (state_q != S_IDLE);
    done              = (state_q == S_DONE);
    addr_output_Row_R = addr_row_q;
    addr_output_Col_R = addr_col_q;
  end

  // Sample selection, length clamp and FIFO occupancy bookkeeping.
  always_comb begin
    sample = '0;
    if (col_mode_q) sample[DATA_DEPTH-1:0] = Q_out_R_col;
    else            sample[DATA_WIDTH-1:0] = Q_out_R_row;
    cur_addr = col_mode_q ? addr_col_q : addr_row_q;
    max_len  = col_mode ? MAX_COL : MAX_ROW;
    n_start  = ((len == '0) || (len > max_len)) ? max_len : len;
    pop      = out_valid & out_ready;
    push     = rd_pend_q;
    // Slots already spoken for: stored words plus the in-flight read, less this cycle's pop.
    occ      = {1'b0, cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop};
    issue_ok = (occ < 3'd2);
  end

  // Next-state logic: FSM, address issue and FIFO pointer updates.
  always_comb begin
    state_d     = state_q;
    col_mode_d  = col_mode_q;
    n_d         = n_q;
    idx_d       = idx_q;
    addr_row_d  = addr_row_q;
    addr_col_d  = addr_col_q;
    rd_pend_d   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_data_d = fifo_data_q;
    fifo_idx_d  = fifo_idx_q;

    if (push) begin
      fifo_data_d[wr_ptr_q] = sample;
      fifo_idx_d[wr_ptr_q]  = cur_addr;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          // Index 0 is issued on the accepting edge so it is addressed in the first busy cycle.
          state_d    = S_READ;
          col_mode_d = col_mode;
          n_d        = n_start;
          idx_d      = ADDR_WIDTH_CAM'(1);
          addr_row_d = '0;
          addr_col_d = '0;
          rd_pend_d  = 1'b1;
        end
      end
      S_READ: begin
        if (idx_q >= n_q) begin
          state_d = S_DRAIN;
        end else if (issue_ok) begin
          idx_d     = idx_q + ADDR_WIDTH_CAM'(1);
          rd_pend_d = 1'b1;
          if (col_mode_q) addr_col_d = idx_q;
          else            addr_row_d = idx_q;
        end
      end
      S_DRAIN: begin
        if (!rd_pend_q && (cnt_d == 2'd0)) state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset; in-flight data is dropped on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      col_mode_q <= 1'b0;
      n_q        <= '0;
      idx_q      <= '0;
      addr_row_q <= '0;
      addr_col_q <= '0;
      rd_pend_q  <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      col_mode_q <= col_mode_d;
      n_q        <= n_d;
      idx_q      <= idx_d;
      addr_row_q <= addr_row_d;
      addr_col_q <= addr_col_d;
      rd_pend_q  <= rd_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  // FIFO storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_idx_q  <= fifo_idx_d;
  end

endmodule

// File: tb/tb_cam_r_unloader.sv
// Bench for cam_r_unloader: combinational CAM model, scoreboard of expected words.
module tb_cam_r_unloader;

  localparam int DW = 4;
  localparam int DD = 4;
  localparam int AW = 8;
  localparam int OW = 4;

  typedef struct {
    logic [OW-1:0] d;
    logic [AW-1:0] i;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          col_mode;
  logic [AW-1:0] len;
  logic          busy;
  logic          done;
  logic [AW-1:0] addr_row;
  logic [AW-1:0] addr_col;
  logic [DW-1:0] q_row;
  logic [DD-1:0] q_col;
  logic [OW-1:0] out_data;
  logic [AW-1:0] out_index;
  logic          out_valid;
  logic          out_ready;

  logic [DW-1:0] cam_mem [DD];
  exp_t          sb_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int words_seen = 0;
  int done_seen  = 0;
  int first_valid_cyc = 0;
  int done_cyc   = 0;
  int start_cyc  = 0;

  logic          mon_pv;
  logic          mon_hp;
  logic [OW-1:0] mon_hd;
  logic [AW-1:0] mon_hi;

  cam_r_unloader #(
    .DATA_WIDTH(DW), .DATA_DEPTH(DD), .ADDR_WIDTH_CAM(AW), .OUT_WIDTH(OW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .col_mode(col_mode), .len(len),
    .busy(busy), .done(done),
    .addr_output_Row_R(addr_row), .addr_output_Col_R(addr_col),
    .Q_out_R_row(q_row), .Q_out_R_col(q_col),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // CAM R model: row read returns a row, column read returns bit j of every row.
  always_comb begin
    q_row = '0;
    q_col = '0;
    if (addr_row < AW'(DD)) q_row = cam_mem[addr_row[1:0]];
    for (int r = 0; r < DD; r++)
      if (addr_col < AW'(DW)) q_col[r] = cam_mem[r][addr_col[1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input bit m, input int l);
    int mx;
    mx = m ? DW : DD;
    return ((l == 0) || (l > mx)) ? mx : l;
  endfunction

  function automatic logic [OW-1:0] exp_word(input bit m, input int i);
    logic [OW-1:0] w;
    w = '0;
    if (!m) w[DW-1:0] = cam_mem[i];
    else for (int r = 0; r < DD; r++) w[r] = cam_mem[r][i];
    return w;
  endfunction

  function automatic logic rdy(input int pat, input int k);
    return (pat == 0) ? 1'b1 : ((k % 3) == 0);
  endfunction

  // Monitor: compares accepted words against the scoreboard and checks stall stability.
  initial begin
    exp_t e;
    mon_pv = 1'b0;
    mon_hp = 1'b0;
    mon_hd = '0;
    mon_hi = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_pv = 1'b0;
        mon_hp = 1'b0;
      end else begin
        if (mon_hp) begin
          chk("hold_data", 32'(out_data), 32'(mon_hd));
          chk("hold_index", 32'(out_index), 32'(mon_hi));
        end
        if (out_valid && !mon_pv) first_valid_cyc = cyc;
        if (out_valid && out_ready) begin
          chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
          if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("word_data", 32'(out_data), 32'(e.d));
            chk("word_index", 32'(out_index), 32'(e.i));
          end
          words_seen++;
        end
        if (done) begin
          done_seen++;
          done_cyc = cyc;
          chk("done_after_last", 32'(sb_q.size()), 32'd0);
        end
        mon_pv = out_valid;
        mon_hp = out_valid && !out_ready;
        mon_hd = out_data;
        mon_hi = out_index;
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_done"},      32'(done),      32'd0);
    chk({tag, "_valid"},     32'(out_valid), 32'd0);
    chk({tag, "_data"},      32'(out_data),  32'd0);
    chk({tag, "_index"},     32'(out_index), 32'd0);
    chk({tag, "_addr_row"},  32'(addr_row),  32'd0);
    chk({tag, "_addr_col"},  32'(addr_col),  32'd0);
  endtask

  task automatic run_sweep(input string tag, input bit m, input int l, input int rpat,
                           input bit dbl, input bit tchk);
    int n, d0, w0, k;
    exp_t e;
    n  = n_of(m, l);
    d0 = done_seen;
    w0 = words_seen;
    for (int i = 0; i < n; i++) begin
      e.d = exp_word(m, i);
      e.i = AW'(i);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; col_mode = m; len = AW'(l); out_ready = rdy(rpat, 0);
    @(negedge clk);
    start_cyc = cyc;
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    k = 1;
    while (done_seen == d0 && k < 200) begin
      @(posedge clk); #1;
      start = (dbl && k == 2);
      if (dbl && k == 2) begin
        col_mode = ~m;
        len      = AW'(1);
      end
      out_ready = rdy(rpat, k);
      if (k == 1) chk({tag, "_busy"}, 32'(busy), 32'd1);
      k++;
    end
    chk({tag, "_no_timeout"}, 32'(k < 200), 32'd1);
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({tag, "_done_count"}, 32'(done_seen - d0), 32'd1);
    chk({tag, "_word_count"}, 32'(words_seen - w0), 32'(n));
    chk({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    if (tchk) begin
      chk({tag, "_first_valid_lat"}, 32'(first_valid_cyc - start_cyc), 32'd2);
      chk({tag, "_done_lat"}, 32'(done_cyc - start_cyc), 32'(n + 2));
    end
  endtask

  initial begin
    int k;
    exp_t e;
    rst = 1'b1; start = 1'b0; col_mode = 1'b0; len = '0; out_ready = 1'b1;
    cam_mem[0] = 4'h1; cam_mem[1] = 4'h2; cam_mem[2] = 4'h4; cam_mem[3] = 4'h8;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("init");
    @(posedge clk); #1 rst = 1'b0;

    run_sweep("row_sweep", 1'b0, 0, 0, 1'b0, 1'b1);
    run_sweep("col_sweep", 1'b1, 0, 0, 1'b0, 1'b1);
    run_sweep("backpressure", 1'b0, 0, 1, 1'b0, 1'b0);
    run_sweep("len2", 1'b0, 2, 0, 1'b0, 1'b1);
    run_sweep("len9", 1'b0, 9, 0, 1'b0, 1'b1);
    run_sweep("dbl_start", 1'b0, 0, 0, 1'b1, 1'b1);

    // Reset while word 1 is waiting at the head of the stream.
    for (int i = 0; i < n_of(1'b0, 0); i++) begin
      e.d = exp_word(1'b0, i);
      e.i = AW'(i);
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b1; col_mode = 1'b0; len = '0; out_ready = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    chk("rst_wait_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    @(negedge clk);
    chk("rst_word1_pending", 32'(out_index), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset("mid_rst");
    @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
    run_sweep("after_rst", 1'b0, 0, 0, 1'b0, 1'b1);

    // Asymmetric contents so a transposition mix-up shows.
    cam_mem[0] = 4'h3; cam_mem[1] = 4'h5; cam_mem[2] = 4'hA; cam_mem[3] = 4'hC;
    run_sweep("col_alt", 1'b1, 0, 1, 1'b0, 1'b0);
    run_sweep("row_alt_len3", 1'b0, 3, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
